// File: rtl/adder_chk_pkg.sv
// Shared definitions for the adder stimulus/response checker.
//   chk_state_e : checker FSM states
//   ERR_SAT     : saturation value of the error counter, also "no error" index
//   CORNER_55/AA: alternating-bit corner operands, sliced to WIDTH by users
//   lfsr_taps() : maximal-length Galois tap mask for a given LFSR length
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  localparam logic [15:0] ERR_SAT   = 16'hFFFF;
  localparam logic [63:0] CORNER_55 = 64'h5555_5555_5555_5555;
  localparam logic [63:0] CORNER_AA = 64'hAAAA_AAAA_AAAA_AAAA;

  // Right-shifting Galois masks; only the lengths 2*{8,16,32} are supported.
  function automatic logic [63:0] lfsr_taps(input int unsigned width2);
    logic [63:0] t;
    case (width2)
      16:      t = 64'h0000_0000_0000_B400;
      32:      t = 64'h0000_0000_8020_0003;
      64:      t = 64'hD800_0000_0000_0000;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/adder_chk_lfsr.sv
// Galois LFSR (right-shifting) with synchronous load and step enables.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (state <= SEED)
//   i_load         : reload SEED (priority over i_step)
//   i_step         : advance one state
//   o_state        : current state
//   o_next         : state that the next step would produce
module adder_chk_lfsr #(
  parameter int unsigned     N    = 16,
  parameter logic [N-1:0]    TAPS = 16'hB400,
  parameter logic [N-1:0]    SEED = 16'h0001
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_step,
  output logic [N-1:0] o_state,
  output logic [N-1:0] o_next
);

  logic [N-1:0] state_q;

  always_comb begin
    o_next = {1'b0, state_q[N-1:1]};
    if (state_q[0]) begin
      o_next = o_next ^ TAPS;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SEED;
    end else if (i_load) begin
      state_q <= SEED;
    end else if (i_step) begin
      state_q <= o_next;
    end
  end

  assign o_state = state_q;

endmodule

// File: rtl/adder_lfsr_checker.sv
// Self-checking stimulus/response stage around a combinational adder.
// Drives four corner vectors then LFSR vectors, compares the adder's
// WIDTH+1-bit result with a behavioural sum, and reports the outcome.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : pulse; starts a run from IDLE or DONE
//   o_add1, o_add2   : operands to the adder under test
//   i_result         : adder sum (combinational from o_add1/o_add2)
//   o_busy           : vectors being applied
//   o_done, o_pass   : run finished / finished with zero errors
//   o_err_count      : mismatches, saturating at 16'hFFFF
//   o_first_err_idx  : index of first mismatch, 16'hFFFF if none
module adder_lfsr_checker
  import adder_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [63:0] SEED        = 64'hACE1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_add1,
  output logic [WIDTH-1:0] o_add2,
  input  logic [WIDTH:0]   i_result,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [15:0]      o_err_count,
  output logic [15:0]      o_first_err_idx
);

  localparam int unsigned     W2         = 2 * WIDTH;
  localparam logic [63:0]     TAPS_ALL   = lfsr_taps(W2);
  localparam logic [W2-1:0]   TAPS       = TAPS_ALL[W2-1:0];
  localparam logic [W2-1:0]   SEED_TRUNC = SEED[W2-1:0];
  localparam logic [W2-1:0]   SEED_EFF   = (SEED_TRUNC == '0) ? W2'(1) : SEED_TRUNC;
  localparam logic [15:0]     LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [WIDTH-1:0] OP_ONES   = '1;
  localparam logic [WIDTH-1:0] OP_ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] OP_55     = CORNER_55[WIDTH-1:0];
  localparam logic [WIDTH-1:0] OP_AA     = CORNER_AA[WIDTH-1:0];

  chk_state_e       state_q, state_d;
  logic [15:0]      idx_q, idx_d, idx_inc;
  logic [WIDTH-1:0] add1_q, add1_d, add2_q, add2_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]      err_q, err_d, err_chk;
  logic [15:0]      first_q, first_d, first_chk;
  logic [WIDTH:0]   expected;
  logic             mismatch;
  logic             lfsr_load, lfsr_step;
  logic [W2-1:0]    lfsr_state, lfsr_next;

  adder_chk_lfsr #(
    .N    (W2),
    .TAPS (TAPS),
    .SEED (SEED_EFF)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (lfsr_load),
    .i_step  (lfsr_step),
    .o_state (lfsr_state),
    .o_next  (lfsr_next)
  );

  assign expected = {1'b0, add1_q} + {1'b0, add2_q};
  assign idx_inc  = idx_q + 16'd1;

  // Default to mismatch and clear only on a true equality, so an unknown
  // result is counted as an error rather than silently passing.
  always_comb begin
    mismatch = 1'b1;
    if (i_result == expected) begin
      mismatch = 1'b0;
    end
  end

  assign err_chk   = (mismatch && (err_q != ERR_SAT)) ? (err_q + 16'd1) : err_q;
  assign first_chk = (mismatch && (first_q == ERR_SAT)) ? idx_q : first_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    add1_d    = add1_q;
    add2_d    = add2_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    first_d   = first_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d   = RUN;
          idx_d     = '0;
          add1_d    = '0;
          add2_d    = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          first_d   = ERR_SAT;
          lfsr_load = 1'b1;
        end
      end
      RUN: begin
        err_d   = err_chk;
        first_d = first_chk;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_chk == '0);
        end else begin
          idx_d = idx_inc;
          // Vector 4 uses the seed itself; later vectors take the stepped
          // value so the register and the operands advance together.
          case (idx_inc)
            16'd1: begin
              add1_d = OP_ONES;
              add2_d = OP_ONES;
            end
            16'd2: begin
              add1_d = OP_ONES;
              add2_d = OP_ONE;
            end
            16'd3: begin
              add1_d = OP_55;
              add2_d = OP_AA;
            end
            16'd4: begin
              add1_d = lfsr_state[W2-1:WIDTH];
              add2_d = lfsr_state[WIDTH-1:0];
            end
            default: begin
              add1_d    = lfsr_next[W2-1:WIDTH];
              add2_d    = lfsr_next[WIDTH-1:0];
              lfsr_step = 1'b1;
            end
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      add1_q  <= '0;
      add2_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= ERR_SAT;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      add1_q  <= add1_d;
      add2_q  <= add2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign o_add1          = add1_q;
  assign o_add2          = add2_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_pass          = pass_q;
  assign o_err_count     = err_q;
  assign o_first_err_idx = first_q;

endmodule

// File: tb/tb_adder_lfsr_checker.sv
module tb_adder_lfsr_checker;

  typedef struct {
    int unsigned err;
    logic [15:0] first;
    logic        pass;
    int unsigned busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_d, start_g, start_s, fault;
  int   total = 0;
  int   bad   = 0;

  exp_t        dut_q[$];
  exp_t        grp_q[$];
  exp_t        sat_q[$];
  logic [15:0] op_q[$];

  // Main 8-bit instance, optionally behind a faulty adder (carry-out stuck 0)
  logic [7:0]  d_a, d_b;
  logic [8:0]  d_sum, d_res;
  logic        d_busy, d_done, d_pass;
  logic [15:0] d_err, d_first;
  assign d_sum = {1'b0, d_a} + {1'b0, d_b};
  assign d_res = fault ? {1'b0, d_sum[7:0]} : d_sum;

  adder_lfsr_checker #(.WIDTH(8), .NUM_VECTORS(256), .SEED(64'hACE1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_d), .o_add1(d_a), .o_add2(d_b),
    .i_result(d_res), .o_busy(d_busy), .o_done(d_done), .o_pass(d_pass),
    .o_err_count(d_err), .o_first_err_idx(d_first));

  // Seed-0 vs seed-1 pair and wider instances, all golden, 40 vectors
  logic [7:0]  s0_a, s0_b, s1_a, s1_b;
  logic        s0_busy, s0_done, s0_pass, s1_busy, s1_done, s1_pass;
  logic [15:0] s0_err, s0_first, s1_err, s1_first;
  logic [15:0] w16_a, w16_b;
  logic        w16_busy, w16_done, w16_pass;
  logic [15:0] w16_err, w16_first;
  logic [31:0] w32_a, w32_b;
  logic        w32_busy, w32_done, w32_pass;
  logic [15:0] w32_err, w32_first;

  adder_lfsr_checker #(.WIDTH(8), .NUM_VECTORS(40), .SEED(64'h0)) u_s0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_g), .o_add1(s0_a), .o_add2(s0_b),
    .i_result({1'b0, s0_a} + {1'b0, s0_b}), .o_busy(s0_busy), .o_done(s0_done),
    .o_pass(s0_pass), .o_err_count(s0_err), .o_first_err_idx(s0_first));

  adder_lfsr_checker #(.WIDTH(8), .NUM_VECTORS(40), .SEED(64'h1)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_g), .o_add1(s1_a), .o_add2(s1_b),
    .i_result({1'b0, s1_a} + {1'b0, s1_b}), .o_busy(s1_busy), .o_done(s1_done),
    .o_pass(s1_pass), .o_err_count(s1_err), .o_first_err_idx(s1_first));

  adder_lfsr_checker #(.WIDTH(16), .NUM_VECTORS(40), .SEED(64'hACE1)) u_w16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_g), .o_add1(w16_a), .o_add2(w16_b),
    .i_result({1'b0, w16_a} + {1'b0, w16_b}), .o_busy(w16_busy), .o_done(w16_done),
    .o_pass(w16_pass), .o_err_count(w16_err), .o_first_err_idx(w16_first));

  adder_lfsr_checker #(.WIDTH(32), .NUM_VECTORS(40), .SEED(64'hACE1)) u_w32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_g), .o_add1(w32_a), .o_add2(w32_b),
    .i_result({1'b0, w32_a} + {1'b0, w32_b}), .o_busy(w32_busy), .o_done(w32_done),
    .o_pass(w32_pass), .o_err_count(w32_err), .o_first_err_idx(w32_first));

  // Always-wrong adder (sum + 1) over the maximum vector count
  logic [7:0]  t_a, t_b;
  logic        t_busy, t_done, t_pass;
  logic [15:0] t_err, t_first;

  adder_lfsr_checker #(.WIDTH(8), .NUM_VECTORS(65535), .SEED(64'hACE1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s), .o_add1(t_a), .o_add2(t_b),
    .i_result({1'b0, t_a} + {1'b0, t_b} + 9'd1), .o_busy(t_busy), .o_done(t_done),
    .o_pass(t_pass), .o_err_count(t_err), .o_first_err_idx(t_first));

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  // Carry-out count for the default-seed 256-vector run: the stuck-at-0
  // fault only corrupts vectors whose true sum exceeds 8 bits.
  function automatic int unsigned model_carry_errs();
    logic [15:0] s;
    int unsigned n;
    s = 16'hACE1;
    n = 2;  // idx1 FF+FF and idx2 FF+01 carry; idx0 and idx3 do not
    for (int i = 4; i < 256; i++) begin
      if ((9'(s[15:8]) + 9'(s[7:0])) > 9'd255) n++;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
    return n;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_add1"},  64'(d_a),     64'h0);
    chk({tag, "_add2"},  64'(d_b),     64'h0);
    chk({tag, "_busy"},  64'(d_busy),  64'h0);
    chk({tag, "_done"},  64'(d_done),  64'h0);
    chk({tag, "_pass"},  64'(d_pass),  64'h0);
    chk({tag, "_err"},   64'(d_err),   64'h0);
    chk({tag, "_first"}, 64'(d_first), 64'hFFFF);
  endtask

  task automatic push_ops();
    op_q.push_back(16'h0000); op_q.push_back(16'hFFFF);
    op_q.push_back(16'hFF01); op_q.push_back(16'h55AA);
    op_q.push_back(16'hACE1); op_q.push_back(16'hE270);
    op_q.push_back(16'h7138); op_q.push_back(16'h389C);
  endtask

  task automatic wait_done(input int sel, input int unsigned budget, input string name);
    bit seen;
    int unsigned n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       seen = d_done;
        1:       seen = s0_done;
        default: seen = t_done;
      endcase
    end
    if (!seen) chk({name, "_timeout"}, 64'h0, 64'h1);
  endtask

  // Monitor: main instance
  initial begin
    int unsigned busy_cnt;
    logic        done_prev;
    exp_t        e;
    logic [15:0] op;
    busy_cnt  = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt  = 0;
        done_prev = 1'b0;
      end else begin
        if (d_busy) begin
          busy_cnt++;
          if (op_q.size() > 0) begin
            op = op_q.pop_front();
            chk("dut_operands", 64'({d_a, d_b}), 64'(op));
          end
        end
        if (d_done && !done_prev) begin
          if (dut_q.size() == 0) begin
            chk("dut_unexpected_done", 64'h1, 64'h0);
          end else begin
            e = dut_q.pop_front();
            chk("dut_err_count", 64'(d_err),   64'(e.err));
            chk("dut_first_idx", 64'(d_first), 64'(e.first));
            chk("dut_pass",      64'(d_pass),  64'(e.pass));
            chk("dut_busy_cyc",  64'(busy_cnt), 64'(e.busy));
          end
          busy_cnt = 0;
        end
        done_prev = d_done;
      end
    end
  end

  // Monitor: seed pair and wide instances
  initial begin
    int unsigned idx;
    logic        done_prev;
    exp_t        e;
    idx       = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (s0_busy) begin
        chk("seed0_vs_seed1", 64'({s0_a, s0_b}), 64'({s1_a, s1_b}));
        if (idx >= 4) chk("seed0_nonzero", 64'({s0_a, s0_b} != 16'h0), 64'h1);
        case (idx)
          4: begin
            chk("seed0_idx4", 64'({s0_a, s0_b}), 64'h0001);
            chk("w16_idx4",   64'({w16_a, w16_b}), 64'h0000_ACE1);
            chk("w32_idx4",   {w32_a, w32_b}, 64'h0000_0000_0000_ACE1);
          end
          5: begin
            chk("seed0_idx5", 64'({s0_a, s0_b}), 64'hB400);
            chk("w16_idx5",   64'({w16_a, w16_b}), 64'h8020_5673);
            chk("w32_idx5",   {w32_a, w32_b}, 64'hD800_0000_0000_5670);
          end
          6: chk("seed0_idx6", 64'({s0_a, s0_b}), 64'h5A00);
          default: ;
        endcase
        idx++;
      end
      if (s0_done && !done_prev) begin
        if (grp_q.size() == 0) begin
          chk("grp_unexpected_done", 64'h1, 64'h0);
        end else begin
          e = grp_q.pop_front();
          chk("grp_busy_cyc", 64'(idx), 64'(e.busy));
          chk("s0_pass",   64'(s0_pass),   64'(e.pass));
          chk("s1_pass",   64'(s1_pass),   64'(e.pass));
          chk("w16_pass",  64'(w16_pass),  64'(e.pass));
          chk("w32_pass",  64'(w32_pass),  64'(e.pass));
          chk("w16_done",  64'(w16_done),  64'h1);
          chk("w32_done",  64'(w32_done),  64'h1);
          chk("s0_err",    64'(s0_err),    64'(e.err));
          chk("w32_err",   64'(w32_err),   64'(e.err));
          chk("s1_first",  64'(s1_first),  64'(e.first));
          chk("w16_first", 64'(w16_first), 64'(e.first));
        end
        idx = 0;
      end
      done_prev = s0_done;
    end
  end

  // Monitor: saturation instance
  initial begin
    int unsigned busy_cnt;
    logic        done_prev;
    exp_t        e;
    busy_cnt  = 0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (t_busy) busy_cnt++;
      if (t_done && !done_prev) begin
        if (sat_q.size() == 0) begin
          chk("sat_unexpected_done", 64'h1, 64'h0);
        end else begin
          e = sat_q.pop_front();
          chk("sat_err_count", 64'(t_err),    64'(e.err));
          chk("sat_first_idx", 64'(t_first),  64'(e.first));
          chk("sat_pass",      64'(t_pass),   64'(e.pass));
          chk("sat_busy_cyc",  64'(busy_cnt), 64'(e.busy));
        end
        busy_cnt = 0;
      end
      done_prev = t_done;
    end
  end

  initial begin
    rst_n   = 1'b0;
    start_d = 1'b0;
    start_g = 1'b0;
    start_s = 1'b0;
    fault   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Golden adder, full run
    push_ops();
    dut_q.push_back('{err: 0, first: 16'hFFFF, pass: 1'b1, busy: 256});
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    wait_done(0, 300, "golden");

    // Carry-out stuck at 0: idx1 fails first
    fault = 1'b1;
    dut_q.push_back('{err: model_carry_errs(), first: 16'd1, pass: 1'b0, busy: 256});
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    wait_done(0, 300, "fault");
    fault = 1'b0;

    // Reset in the middle of a run, then a clean run
    dut_q.push_back('{err: 0, first: 16'hFFFF, pass: 1'b1, busy: 256});
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("midrun_reset");
    dut_q.delete();
    op_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_ops();
    dut_q.push_back('{err: 0, first: 16'hFFFF, pass: 1'b1, busy: 256});
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    wait_done(0, 300, "after_reset");

    // Start pulse during RUN is ignored
    push_ops();
    dut_q.push_back('{err: 0, first: 16'hFFFF, pass: 1'b1, busy: 256});
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    repeat (49) @(negedge clk);
    start_d = 1'b1; @(negedge clk); start_d = 1'b0;
    wait_done(0, 300, "restart_ignored");

    // Seed 0 vs seed 1, 16- and 32-bit widths
    grp_q.push_back('{err: 0, first: 16'hFFFF, pass: 1'b1, busy: 40});
    start_g = 1'b1; @(negedge clk); start_g = 1'b0;
    wait_done(1, 80, "group");

    // Every vector wrong over 65535 vectors
    sat_q.push_back('{err: 65535, first: 16'h0000, pass: 1'b0, busy: 65535});
    start_s = 1'b1; @(negedge clk); start_s = 1'b0;
    wait_done(2, 65600, "saturate");

    repeat (3) @(negedge clk);
    chk("dut_queue_drained", 64'(dut_q.size()), 64'h0);
    chk("grp_queue_drained", 64'(grp_q.size()), 64'h0);
    chk("sat_queue_drained", 64'(sat_q.size()), 64'h0);
    chk("op_queue_drained",  64'(op_q.size()),  64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
